result_frame_buffer: RTL and testbench
======================================

Name: result_frame_buffer

Overview:
Downstream of eig_core. Captures each finished result (regime, kappa, inv_kappa) on the core's one-cycle result pulse into a small frame FIFO. Drains the FIFO as framed byte streams over a valid/ready byte interface toward the output pins. Decouples core throughput from pin-side pacing and counts results lost to overflow.

Parameters:
DEPTH, 4, number of buffered result frames; power of two, minimum 2
WORD_W, 32, width of kappa and inv_kappa in bits; fixed at 32 for this revision

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
res_valid  input  1  one-cycle pulse from eig_core: result fields valid
regime  input  3  eig_core regime code
kappa  input  WORD_W  eig_core kappa, signed
inv_kappa  input  WORD_W  eig_core inverse kappa, signed
out_byte  output  8  current frame byte
out_valid  output  1  out_byte valid
out_ready  input  1  consumer accepts out_byte this cycle
frame_start  output  1  high while out_byte is a header byte
buf_full  output  1  all DEPTH entries occupied
buf_count  output  $clog2(DEPTH)+1  occupied entries
drop_cnt  output  8  results dropped due to full buffer, saturating

Behaviour:
- Reset (rst=1, async): FIFO empty, rd/wr pointers 0, seq=0, byte_idx=0, state IDLE. Outputs: out_byte=0, out_valid=0, frame_start=0, buf_full=0, buf_count=0, drop_cnt=0. A partial frame in flight is discarded; no resume after reset.
- Entry layout: {seq[3:0], regime[2:0], kappa, inv_kappa}. Registered on the res_valid cycle.
- seq: 4-bit counter, incremented per accepted result, wraps 15->0. Dropped results do not increment it.
- Frame bytes, 9 without the optional feature:
  - B0 = {1'b1, regime, seq}
  - B1..B4 = kappa[31:24], [23:16], [15:8], [7:0]
  - B5..B8 = inv_kappa, MSB first
- Push: res_valid=1 and the buffer is not full after same-cycle pop -> entry written, buf_count+1.
- Drop: res_valid=1 with the buffer full and no same-cycle frame completion -> entry discarded, drop_cnt+1, saturating at 255.
- Pop: an entry is freed in the cycle its last byte handshakes (out_valid & out_ready on the final byte).
- Simultaneous push and last-byte pop while full: push accepted, buf_count unchanged, buf_full stays 1.
- State machine:
  - IDLE: buf_count>0 -> SEND, byte_idx=0.
  - SEND: out_valid=1. On handshake, byte_idx+1. After the last byte -> IDLE, or stay in SEND with byte_idx=0 if another entry is pending, giving back-to-back frames with no bubble.
- Latency: res_valid in cycle N with the buffer empty -> out_valid=1 with the header byte in cycle N+1.
- Output stability: out_byte is registered and held stable while out_valid=1 and out_ready=0. Bytes never change without a handshake.
- frame_start=1 exactly when out_valid=1 and byte_idx=0.
- buf_full = (buf_count==DEPTH). buf_count includes the entry currently being sent.

Optional Feature:
RESULT_FRAME_CHECKSUM_EN:
- Defined: a tenth byte B9 = XOR of B0..B8 is appended, and the frame completes after B9.
- Undefined: the frame is 9 bytes and no checksum logic is present.

Test Plan:
- Single frame: reset; regime=3'b010, kappa=32'h00018000, inv_kappa=32'h0000AAAA, one res_valid pulse, out_ready=1 -> out_valid rises the next cycle; bytes A0 00 01 80 00 00 00 AA AA. With RESULT_FRAME_CHECKSUM_EN, bytes continue with 21. frame_start=1 only on A0.
- Backpressure: same result, out_ready toggled 1,0,0,1,... -> out_byte held across stalls; byte order unchanged; buf_count=1 until the last handshake, then 0.
- Overflow: DEPTH=4, out_ready=0, six res_valid pulses -> buf_full=1 after the 4th; drop_cnt=2; the drained headers carry seq 0,1,2,3.
- Full push/pop collision: buffer full, res_valid coincides with the final-byte handshake -> result accepted, drop_cnt unchanged, buf_count stays 4. The next frame follows with no idle cycle.
- Seq wrap and saturation: 17 accepted results drained in order -> the 17th header has seq=0. Force 300 drops -> drop_cnt=255.
- Reset mid-frame: assert rst after B3 handshakes -> all outputs 0 immediately. After release with no new res_valid, out_valid stays 0.

Source files
------------

// File: rtl/result_frame_buffer.sv
// result_frame_buffer: captures eig_core results into a small frame FIFO and
// drains each entry as a framed byte stream over a valid/ready interface.
// Frame: header {1, regime, seq}, kappa MSB first, inv_kappa MSB first.
// Optional macro RESULT_FRAME_CHECKSUM_EN appends an XOR checksum byte.
module result_frame_buffer #(
   parameter int DEPTH  = 4,
   parameter int WORD_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       res_valid,
   input  logic [2:0]                 regime,
   input  logic signed [WORD_W-1:0]   kappa,
   input  logic signed [WORD_W-1:0]   inv_kappa,
   output logic [7:0]                 out_byte,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       frame_start,
   output logic                       buf_full,
   output logic [$clog2(DEPTH):0]     buf_count,
   output logic [7:0]                 drop_cnt
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = 4 + 3 + 2 * WORD_W;
`ifdef RESULT_FRAME_CHECKSUM_EN
   localparam logic [3:0] LAST_IDX = 4'd9;
`else
   localparam logic [3:0] LAST_IDX = 4'd8;
`endif

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state, state_nx;
   logic [ENTRY_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    count;
   logic [3:0]          seq;
   logic [3:0]          byte_idx, idx_nx;
   logic [7:0]          byte_nx;
   logic [ENTRY_W-1:0]  new_entry, head, next_head;
   logic                hs, last, pop, push, drop, full;

   // Payload bytes of an entry (header, kappa, inv_kappa)
   function automatic logic [7:0] data_byte(input logic [ENTRY_W-1:0] e,
                                            input logic [3:0] idx);
      logic [WORD_W-1:0] k;
      logic [WORD_W-1:0] ik;
      k  = e[2*WORD_W-1:WORD_W];
      ik = e[WORD_W-1:0];
      case (idx)
         4'd0:    return {1'b1, e[ENTRY_W-5 -: 3], e[ENTRY_W-1 -: 4]};
         4'd1:    return k[31:24];
         4'd2:    return k[23:16];
         4'd3:    return k[15:8];
         4'd4:    return k[7:0];
         4'd5:    return ik[31:24];
         4'd6:    return ik[23:16];
         4'd7:    return ik[15:8];
         4'd8:    return ik[7:0];
         default: return 8'h00;
      endcase
   endfunction

   // Complete frame byte, including the checksum when enabled
   function automatic logic [7:0] frame_byte(input logic [ENTRY_W-1:0] e,
                                             input logic [3:0] idx);
`ifdef RESULT_FRAME_CHECKSUM_EN
      logic [7:0] x;
      x = 8'h00;
      if (idx == 4'd9) begin
         for (int i = 0; i < 9; i++) x ^= data_byte(e, 4'(i));
      end else begin
         x = data_byte(e, idx);
      end
      return x;
`else
      return data_byte(e, idx);
`endif
   endfunction

   assign new_entry   = {seq, regime, kappa, inv_kappa};
   assign head        = mem[rd_ptr];
   assign next_head   = mem[rd_ptr + PTR_W'(1)];
   assign out_valid   = (state == SEND);
   assign frame_start = out_valid & (byte_idx == 4'd0);
   assign buf_full    = full;
   assign buf_count   = count;

   // Handshake, push/pop/drop decisions and next-state / next-byte selection
   always_comb begin
      full     = (count == CNT_W'(DEPTH));
      hs       = (state == SEND) & out_ready;
      last     = (byte_idx == LAST_IDX);
      pop      = hs & last;
      push     = res_valid & (~full | pop);
      drop     = res_valid & full & ~pop;
      state_nx = state;
      idx_nx   = byte_idx;
      byte_nx  = out_byte;
      case (state)
         IDLE: begin
            if (count != '0) begin
               state_nx = SEND;
               idx_nx   = 4'd0;
               byte_nx  = frame_byte(head, 4'd0);
            end else if (push) begin
               // Empty buffer: present the header straight from the incoming result
               state_nx = SEND;
               idx_nx   = 4'd0;
               byte_nx  = frame_byte(new_entry, 4'd0);
            end
         end
         SEND: begin
            if (hs) begin
               if (!last) begin
                  idx_nx  = byte_idx + 4'd1;
                  byte_nx = frame_byte(head, byte_idx + 4'd1);
               end else if (count > CNT_W'(1)) begin
                  idx_nx  = 4'd0;
                  byte_nx = frame_byte(next_head, 4'd0);
               end else if (push) begin
                  idx_nx  = 4'd0;
                  byte_nx = frame_byte(new_entry, 4'd0);
               end else begin
                  state_nx = IDLE;
                  idx_nx   = 4'd0;
                  byte_nx  = 8'h00;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            idx_nx   = 4'd0;
            byte_nx  = 8'h00;
         end
      endcase
   end

   // State, byte position and registered output byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         byte_idx <= 4'd0;
         out_byte <= 8'h00;
      end else begin
         state    <= state_nx;
         byte_idx <= idx_nx;
         out_byte <= byte_nx;
      end
   end

   // FIFO pointers, occupancy, sequence number and drop counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         seq      <= 4'd0;
         drop_cnt <= 8'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            seq    <= seq + 4'd1;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
   end

   // Entry storage; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= new_entry;
   end

endmodule

// File: tb/tb_result_frame_buffer.sv
// Bench for result_frame_buffer: scoreboard of expected frame bytes versus
// bytes observed on each out_valid & out_ready handshake.
module tb_result_frame_buffer;

`ifdef RESULT_FRAME_CHECKSUM_EN
   localparam int FLEN = 10;
`else
   localparam int FLEN = 9;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        res_valid = 1'b0;
   logic [2:0]  regime = 3'd0;
   logic [31:0] kappa = 32'd0;
   logic [31:0] inv_kappa = 32'd0;
   logic        out_ready = 1'b0;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        frame_start;
   logic        buf_full;
   logic [2:0]  buf_count;
   logic [7:0]  drop_cnt;

   int errors = 0;
   int checks = 0;
   logic [3:0] m_seq = 4'd0;
   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];

   result_frame_buffer #(.DEPTH(4), .WORD_W(32)) dut (
      .clk(clk), .rst(rst), .res_valid(res_valid), .regime(regime),
      .kappa(kappa), .inv_kappa(inv_kappa), .out_byte(out_byte),
      .out_valid(out_valid), .out_ready(out_ready), .frame_start(frame_start),
      .buf_full(buf_full), .buf_count(buf_count), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Record a handshake that will occur at the coming edge, then advance one cycle
   task automatic tick();
      if (out_valid && out_ready) obs_q.push_back({frame_start, out_byte});
      @(posedge clk);
      #1;
   endtask

   // Reference frame of a result accepted with the model's sequence number
   task automatic push_exp(input logic [2:0] r, input logic [31:0] k, input logic [31:0] ik);
      logic [7:0] b [9];
      logic [7:0] x;
      b[0] = {1'b1, r, m_seq};
      b[1] = k[31:24];  b[2] = k[23:16];  b[3] = k[15:8];  b[4] = k[7:0];
      b[5] = ik[31:24]; b[6] = ik[23:16]; b[7] = ik[15:8]; b[8] = ik[7:0];
      x = 8'h00;
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back({(i == 0), b[i]});
         x ^= b[i];
      end
`ifdef RESULT_FRAME_CHECKSUM_EN
      exp_q.push_back({1'b0, x});
`endif
      m_seq = m_seq + 4'd1;
   endtask

   task automatic send(input logic [2:0] r, input logic [31:0] k, input logic [31:0] ik,
                       input bit accept);
      regime = r; kappa = k; inv_kappa = ik; res_valid = 1'b1;
      if (accept) push_exp(r, k, ik);
      tick();
      res_valid = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1; res_valid = 1'b0; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      m_seq = 4'd0;
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++; if (out_byte !== 8'h00) begin errors++; $display("FAIL reset_out_byte: got %h want 00", out_byte); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
      checks++; if (buf_full !== 1'b0) begin errors++; $display("FAIL reset_buf_full: got %b want 0", buf_full); end
      checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL reset_buf_count: got %0d want 0", buf_count); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
      apply_reset();
   endtask

   task automatic test_single();
      logic [8:0] o, e;
      apply_reset();
      out_ready = 1'b1;
      send(3'b010, 32'h00018000, 32'h0000AAAA, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: out_valid %b want 1", out_valid); end
      checks++; if (out_byte !== 8'hA0) begin errors++; $display("FAIL single_header: got %h want A0", out_byte); end
      checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL single_frame_start: got %b want 1", frame_start); end
      repeat (FLEN + 3) tick();
      checks++; if (out_valid !== 1'b0 || buf_count !== 3'd0) begin errors++; $display("FAIL single_idle: valid %b count %0d want 0 0", out_valid, buf_count); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL single_len: got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL single_byte: got %h want %h", o, e); end
      end
   endtask

   task automatic test_backpressure();
      logic [8:0] o, e;
      logic [7:0] prev;
      bit stalled;
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      apply_reset();
      send(3'b010, 32'h00018000, 32'h0000AAAA, 1'b1);
      for (int i = 0; i < 80 && obs_q.size() < FLEN; i++) begin
         out_ready = pat[i % 4];
         prev = out_byte;
         stalled = out_valid && !out_ready;
         if (out_valid) begin
            checks++; if (buf_count !== 3'd1) begin errors++; $display("FAIL bp_count: got %0d want 1", buf_count); end
         end
         tick();
         if (stalled) begin
            checks++; if (out_byte !== prev || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got %h/%b want %h/1", out_byte, out_valid, prev); end
         end
      end
      out_ready = 1'b1;
      checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL bp_count_end: got %0d want 0", buf_count); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_len: got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL bp_byte: got %h want %h", o, e); end
      end
   endtask

   task automatic test_overflow();
      logic [8:0] o, e;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         send(3'(i + 1), 32'h11223344 + i, 32'hCAFE0000 + i, i < 4);
         if (i == 3) begin
            checks++; if (buf_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", buf_full); end
         end
      end
      checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop: got %0d want 2", drop_cnt); end
      checks++; if (buf_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", buf_count); end
      out_ready = 1'b1;
      repeat (4 * FLEN + 4) tick();
      checks++; if (buf_count !== 3'd0 || buf_full !== 1'b0) begin errors++; $display("FAIL ovf_drain: count %0d full %b want 0 0", buf_count, buf_full); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_len: got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL ovf_byte: got %h want %h", o, e); end
      end
   endtask

   task automatic test_collision();
      logic [8:0] o, e;
      apply_reset();
      for (int i = 0; i < 4; i++) send(3'(i), 32'h80000000 | i, 32'h7FFFFFF0 + i, 1'b1);
      out_ready = 1'b1;
      repeat (FLEN - 1) tick();
      send(3'b111, 32'hDEADBEEF, 32'h01020304, 1'b1);
      checks++; if (buf_count !== 3'd4 || buf_full !== 1'b1) begin errors++; $display("FAIL col_count: count %0d full %b want 4 1", buf_count, buf_full); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL col_drop: got %0d want 0", drop_cnt); end
      checks++; if (out_valid !== 1'b1 || frame_start !== 1'b1) begin errors++; $display("FAIL col_no_bubble: valid %b start %b want 1 1", out_valid, frame_start); end
      repeat (4 * FLEN + 4) tick();
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL col_len: got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL col_byte: got %h want %h", o, e); end
      end
   endtask

   task automatic test_seq_wrap();
      logic [8:0] o, e, hdr17;
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         send(3'(i), 32'h01000000 * i, 32'hFFFFFFFF - i, 1'b1);
         repeat (FLEN) tick();
      end
      repeat (FLEN) tick();
      hdr17 = (obs_q.size() > 16 * FLEN) ? obs_q[16 * FLEN] : 9'h000;
      checks++; if (hdr17 !== 9'h180) begin errors++; $display("FAIL wrap_hdr17: got %h want 180", hdr17); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_len: got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL wrap_byte: got %h want %h", o, e); end
      end
      out_ready = 1'b0;
      for (int i = 0; i < 304; i++) send(3'd5, 32'h5, 32'h6, i < 4);
      checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop: got %0d want 255", drop_cnt); end
      checks++; if (buf_count !== 3'd4) begin errors++; $display("FAIL sat_count: got %0d want 4", buf_count); end
   endtask

   task automatic test_reset_midframe();
      bit stray;
      apply_reset();
      out_ready = 1'b1;
      send(3'b010, 32'h00018000, 32'h0000AAAA, 1'b1);
      for (int i = 0; i < 20 && obs_q.size() < 4; i++) tick();
      checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL mid_reach: got %0d bytes want 4", obs_q.size()); end
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_byte !== 8'h00 || frame_start !== 1'b0) begin errors++; $display("FAIL mid_outputs: valid %b byte %h start %b want 0 00 0", out_valid, out_byte, frame_start); end
      checks++; if (buf_count !== 3'd0 || buf_full !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL mid_status: count %0d full %b drop %0d want 0 0 0", buf_count, buf_full, drop_cnt); end
      tick();
      rst = 1'b0;
      stray = 1'b0;
      repeat (20) begin
         tick();
         if (out_valid !== 1'b0) stray = 1'b1;
      end
      checks++; if (stray) begin errors++; $display("FAIL mid_resume: out_valid rose after reset, want 0"); end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_overflow();
      test_collision();
      test_seq_wrap();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
